// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline hazard bus between the core datapath and the hazard controller.
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             ex_reg_write, mem_reg_write, wb_reg_write;
    logic [1:0]       ex_result_src;
    logic             ex_pc_src, mem_req, mem_ready;
    logic             dbg_halt_req, dbg_step, dbg_resume;
    logic             fe_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear;
    logic [1:0]       fwd_a, fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    modport master (
        output de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_reg_write, mem_reg_write, wb_reg_write, ex_result_src,
               ex_pc_src, mem_req, mem_ready, dbg_halt_req, dbg_step, dbg_resume,
        input  fe_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear,
               fwd_a, fwd_b, halted, stall_cycles, flush_count
    );

    modport slave (
        input  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_reg_write, mem_reg_write, wb_reg_write, ex_result_src,
               ex_pc_src, mem_req, mem_ready, dbg_halt_req, dbg_step, dbg_resume,
        output fe_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear,
               fwd_a, fwd_b, halted, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: 5-stage pipeline stall/flush/forwarding sequencer with debug halt/step and perf counters.
module hazard_controller #(
    parameter int         CNT_W    = 16,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

    state_t           state;
    logic             halt_pend;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_wait, lu, in_halt;
    logic             mem_a, wb_a, mem_b, wb_b;

    assign mem_wait = bus.mem_req & ~bus.mem_ready;
    assign lu = bus.ex_reg_write && bus.ex_result_src == LOAD_SRC && bus.ex_rd != 5'd0 &&
                (bus.ex_rd == bus.de_rs1 || bus.ex_rd == bus.de_rs2);
    assign in_halt = state == HALTED;

    assign mem_a = bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs1;
    assign wb_a  = bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs1;
    assign mem_b = bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs2;
    assign wb_b  = bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs2;

    assign bus.fwd_a = !rst_n ? 2'b00 : mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    assign bus.fwd_b = !rst_n ? 2'b00 : mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
    assign bus.halted = rst_n & in_halt;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count = flush_cnt;

    // Reset forces a bubble into decode/execute; memory wait beats flush, flush beats halt and load-use.
    always_comb begin
        bus.fe_stall  = 1'b0;
        bus.de_stall  = 1'b0;
        bus.ex_stall  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.de_clear  = 1'b0;
        bus.ex_clear  = 1'b0;
        if (!rst_n) begin
            bus.fe_stall = 1'b1;
            bus.de_stall = 1'b1;
            bus.de_clear = 1'b1;
            bus.ex_clear = 1'b1;
        end else if (mem_wait) begin
            bus.fe_stall  = 1'b1;
            bus.de_stall  = 1'b1;
            bus.ex_stall  = 1'b1;
            bus.mem_stall = 1'b1;
        end else if (bus.ex_pc_src) begin
            bus.de_clear = 1'b1;
            bus.ex_clear = 1'b1;
        end else if (in_halt || lu) begin
            bus.fe_stall = 1'b1;
            bus.de_stall = 1'b1;
            bus.ex_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            halt_pend <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN:
                    if (mem_wait) halt_pend <= halt_pend | bus.dbg_halt_req;
                    else if (bus.dbg_halt_req || halt_pend) begin
                        state     <= HALTED;
                        halt_pend <= 1'b0;
                    end
                HALTED:
                    if (bus.dbg_resume) state <= RUN;
                    else if (bus.dbg_step) state <= STEP;
                STEP:
                    if (!mem_wait && !lu) state <= HALTED;
                default: state <= RUN;
            endcase
            if (bus.de_stall && !in_halt && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.ex_pc_src && !mem_wait && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage core (fetch, decode, execute, memory, writeback).
- Produces per-stage stall and clear strobes, and EX operand forwarding selects.
- Holds the pipeline frozen while data memory is not ready.
- Implements a debug run/halt/single-step state machine.
- Keeps saturating stall and flush performance counters.
- The decode-to-execute register consumes `ex_clear`. The fetch/decode registers consume `fe_stall`, `de_stall` and `de_clear`.

Parameters:
- CNT_W, 16, width of the performance counters.
- LOAD_SRC, 2'b01, `result_src` encoding that marks a load.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- de_rs1, de_rs2  in  5 each  source registers of the instruction in decode.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in execute.
- ex_rd  in  5  destination register in execute.
- ex_reg_write  in  1  execute instruction writes the register file.
- ex_result_src  in  2  result select of the execute instruction.
- ex_pc_src  in  1  taken branch/jump resolved in execute.
- mem_rd  in  5  destination register in memory.
- mem_reg_write  in  1  memory instruction writes the register file.
- mem_req  in  1  memory-stage load/store active.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  5  destination register in writeback.
- wb_reg_write  in  1  writeback instruction writes the register file.
- dbg_halt_req, dbg_step, dbg_resume  in  1 each  single-cycle debug pulses.
- fe_stall, de_stall, ex_stall, mem_stall  out  1 each  hold the corresponding pipeline register.
- de_clear, ex_clear  out  1 each  load a bubble into decode / execute.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result.
- halted  out  1  core is halted.
- stall_cycles, flush_count  out  CNT_W each  performance counters.

Behaviour:
- Register x0 never matches in any hazard or forwarding comparison (rd==0 is ignored).
- Forwarding, combinational:
  - fwd_a = 10 if mem_reg_write & mem_rd==ex_rs1.
  - Otherwise fwd_a = 01 if wb_reg_write & wb_rd==ex_rs1.
  - Otherwise fwd_a = 00.
  - Memory stage has priority over writeback. fwd_b is identical using ex_rs2.
- Hazard terms, combinational:
  - mem_wait = mem_req & ~mem_ready.
  - lu = ex_reg_write & ex_result_src==LOAD_SRC & ex_rd!=0 & (ex_rd==de_rs1 | ex_rd==de_rs2).
- Strobe priority, combinational from the current state:
  1. mem_wait: all four stalls = 1; de_clear = ex_clear = 0.
  2. ex_pc_src: de_clear = ex_clear = 1; no stalls (any load-use is on the wrong path and is discarded).
  3. lu: fe_stall = de_stall = 1, ex_clear = 1; exactly one bubble per load-use.
  4. Otherwise all strobes = 0.
- State machine (registered `state`):
  - RUN:
    - dbg_halt_req & ~mem_wait -> HALTED.
    - dbg_halt_req during mem_wait is latched in `halt_pend` and taken on the first cycle mem_wait is 0.
  - HALTED:
    - fe_stall = de_stall = 1, ex_clear = 1, so older instructions drain. mem_wait still forces all stalls.
    - halted = 1.
    - dbg_resume -> RUN (resume wins if it arrives with dbg_step in the same cycle).
    - dbg_step -> STEP.
  - STEP:
    - Strobes computed exactly as in RUN, so one instruction advances from decode.
    - Stays in STEP while mem_wait or lu is true, so exactly one instruction enters execute.
    - Then -> HALTED.
  - During HALTED, ex_pc_src still clears de/ex (the flush applies over the halt strobes).
- Counters:
  - stall_cycles increments on each cycle with de_stall=1 while state!=HALTED.
  - flush_count increments on each cycle with ex_pc_src=1 and mem_wait=0.
  - Both saturate at all-ones (no wrap).
- Reset, rst_n=0 at a clock edge:
  - state = RUN, halt_pend = 0, counters = 0.
  - While rst_n is low, combinational outputs are forced: fe_stall = de_stall = 1, de_clear = ex_clear = 1, ex_stall = mem_stall = 0, fwd_a = fwd_b = 00, halted = 0.
  - Reset mid-STEP or mid-HALTED returns to RUN.

Test Plan:
- Forwarding: mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1, ex_rs1=5 -> fwd_a=10. Same with mem_reg_write=0 -> fwd_a=01. Same with ex_rs1=0 -> fwd_a=00.
- Load-use: ex_result_src=01, ex_rd=3, ex_reg_write=1, de_rs2=3 -> one cycle with fe_stall=de_stall=ex_clear=1 and stall_cycles=1. With ex_rd=0 -> no stall.
- Branch vs load-use: ex_pc_src=1 together with the load-use condition above -> de_clear=ex_clear=1, fe_stall=0, flush_count increments by 1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, with ex_pc_src=1 also held -> all stalls=1 and clears=0 for 3 cycles. Flush occurs on the cycle mem_ready=1.
- Debug:
  - dbg_halt_req during mem_wait -> halted rises the cycle after mem_ready.
  - dbg_step -> exactly one decode advance, then halted=1 again.
  - dbg_resume -> RUN, halted=0.
- Reset and saturation:
  - Preload stall_cycles to 0xFFFF by a long stall -> stays 0xFFFF.
  - rst_n=0 for one edge while in STEP -> counters=0, state RUN, forced strobes visible while rst_n low.
